dmem_responder: RTL

Multi-cycle data-memory responder for the MEM stage of the hazard-handled RV32 pipeline. It serves the load/store requests the MEM stage issues (MemRead/MemWrite, address, store data) with a configurable access latency. It holds `Busy` high so the hazard unit stalls the pipeline until the access completes. It also handles byte/halfword/word lane selection, load sign/zero extension and access-fault detection.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : MEM-stage load/store request and response bundle between the
//                pipeline (master) and the data-memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic [31:0] MemData_out;
  logic        Busy;
  logic        DataValid;
  logic        AccessFault;

  modport master (
    output MemRead, MemWrite, Address, WriteData, Funct3,
    input  MemData_out, Busy, DataValid, AccessFault
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData, Funct3,
    output MemData_out, Busy, DataValid, AccessFault
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the MEM stage. Accepts
//                a load/store in IDLE, spends LATENCY cycles in ACCESS, then
//                pulses DataValid for one cycle in DONE. Handles byte/half/word
//                lanes, load extension and misaligned/illegal request faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned c_addr_w   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [c_addr_w+1:0] addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          f3_q;
  logic                wr_q;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [DEPTH_WORDS];

  logic                w_req;
  logic                w_bad;
  logic                w_idle;
  logic                w_accept;
  logic                w_commit;
  logic [c_addr_w-1:0] w_idx;
  logic [3:0]          w_be;
  logic [31:0]         w_wlane;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic                w_unused_addr_hi;

  // Address bits above the memory window are ignored so accesses wrap.
  assign w_unused_addr_hi = ^bus.Address[31:c_addr_w+2];

  assign w_req    = bus.MemRead | bus.MemWrite;
  assign w_idle   = (state_q == S_IDLE);
  assign w_accept = ~reset & w_idle & w_req & ~w_bad;
  assign w_commit = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  // Request legality: conflicting strobes, illegal size code, or misalignment.
  always_comb begin
    w_bad = 1'b0;
    if (bus.MemRead && bus.MemWrite) begin
      w_bad = 1'b1;
    end else if (bus.MemWrite) begin
      case (bus.Funct3)
        3'b000:  w_bad = 1'b0;
        3'b001:  w_bad = bus.Address[0];
        3'b010:  w_bad = |bus.Address[1:0];
        default: w_bad = 1'b1;
      endcase
    end else begin
      case (bus.Funct3)
        3'b000, 3'b100: w_bad = 1'b0;
        3'b001, 3'b101: w_bad = bus.Address[0];
        3'b010:         w_bad = |bus.Address[1:0];
        default:        w_bad = 1'b1;
      endcase
    end
  end

  // Reset forces all handshake outputs low for the reset cycle itself.
  assign bus.AccessFault = ~reset & w_idle & w_req & w_bad;
  assign bus.Busy        = w_accept | (~reset & (state_q == S_ACCESS));
  assign bus.DataValid   = ~reset & (state_q == S_DONE);
  assign bus.MemData_out = rdata_q;

  // State register and access countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> ACCESS (LATENCY cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_ACCESS;
          cnt_d   = c_cnt_init;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the request on acceptance; capture load data on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (w_accept) begin
        addr_q  <= bus.Address[c_addr_w+1:0];
        wdata_q <= bus.WriteData;
        f3_q    <= bus.Funct3;
        wr_q    <= bus.MemWrite;
      end
      if (w_commit && !wr_q) begin
        rdata_q <= w_load;
      end
    end
  end

  assign w_idx = addr_q[c_addr_w+1:2];

  // Store lane replication and byte enables from the latched size/offset.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        w_wlane = {4{wdata_q[7:0]}};
        w_be    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        w_wlane = {2{wdata_q[15:0]}};
        w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wlane = wdata_q;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    w_word = mem_q[w_idx];
    w_byte = w_word[{addr_q[1:0], 3'b000} +: 8];
    w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];
    case (f3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end

  // Storage: cleared on reset, written only on a store's final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_commit && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
